// File: rtl/me_pkg.sv
// Shared types, default geometry and width helper for the motion-estimation sequencer.
package me_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} me_state_e;

  localparam int unsigned DEF_N      = 16;
  localparam int unsigned DEF_V      = 16;
  localparam int unsigned DEF_OFFSET = 7;
  localparam int unsigned DEF_VEC_W  = 4;

  // Bits needed to index 'value' entries; never narrower than one bit.
  function automatic int unsigned me_width(input int unsigned value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/me_addr_gen.sv
// Combinational decode of the sequencer count into memory addresses and the motion vector.
module me_addr_gen
  import me_pkg::*;
#(
  parameter  int unsigned N      = DEF_N,
  parameter  int unsigned V      = DEF_V,
  parameter  int unsigned OFFSET = DEF_OFFSET,
  parameter  int unsigned VEC_W  = DEF_VEC_W,
  localparam int unsigned LOG2N  = me_width(N),
  localparam int unsigned LAST   = V * N * N + N,
  localparam int unsigned CW     = me_width(LAST + 1),
  localparam int unsigned VYW    = CW - 2 * LOG2N,
  localparam int unsigned S1W    = me_width(2 * N * (V + N)),
  localparam int unsigned S2W    = me_width(N * (V + N))
) (
  input  logic [CW-1:0]      count,
  output logic [2*LOG2N-1:0] AddressR,
  output logic [S1W-1:0]     AddressS1,
  output logic [S2W-1:0]     AddressS2,
  output logic [VEC_W-1:0]   VectorX,
  output logic [VEC_W-1:0]   VectorY
);

  logic [LOG2N-1:0] col;
  logic [LOG2N-1:0] row;
  logic [VYW-1:0]   vy;
  logic [31:0]      line;

  assign col  = count[LOG2N-1:0];
  assign row  = count[2*LOG2N-1:LOG2N];
  assign vy   = count[CW-1:2*LOG2N];
  // Search-window line: vertical offset plus row inside the reference block.
  assign line = 32'(vy) + 32'(row);

  assign AddressR  = count[2*LOG2N-1:0];
  assign AddressS1 = S1W'((line << (LOG2N + 1)) + 32'(col));
  assign AddressS2 = S2W'((line << LOG2N) + 32'(col));
  assign VectorX   = VEC_W'(32'(col) - OFFSET);
  assign VectorY   = VEC_W'(32'(vy) - OFFSET);

endmodule

// File: rtl/me_control_param.sv
// Parametrised full-search motion-estimation sequencer: FSM, pixel counter and PE strobes.
// Optional stall input enabled by defining ME_STALL_EN.
module me_control_param
  import me_pkg::*;
#(
  parameter  int unsigned N      = DEF_N,
  parameter  int unsigned V      = DEF_V,
  parameter  int unsigned OFFSET = DEF_OFFSET,
  parameter  int unsigned VEC_W  = DEF_VEC_W,
  localparam int unsigned LOG2N  = me_width(N),
  localparam int unsigned LAST   = V * N * N + N,
  localparam int unsigned CW     = me_width(LAST + 1),
  localparam int unsigned S1W    = me_width(2 * N * (V + N)),
  localparam int unsigned S2W    = me_width(N * (V + N))
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
`ifdef ME_STALL_EN
  input  logic               stall,
`endif
  output logic [N-1:0]       S1S2mux,
  output logic [N-1:0]       NewDist,
  output logic               CompStart,
  output logic [N-1:0]       PEready,
  output logic [VEC_W-1:0]   VectorX,
  output logic [VEC_W-1:0]   VectorY,
  output logic [2*LOG2N-1:0] AddressR,
  output logic [S1W-1:0]     AddressS1,
  output logic [S2W-1:0]     AddressS2,
  output logic               busy,
  output logic               done
);

  localparam logic [CW-1:0] LastCount = CW'(LAST);
  localparam logic [CW-1:0] BlockSize = CW'(N * N);

  me_state_e     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          stalled;
  logic          first_px;
  logic          comp_on;

`ifdef ME_STALL_EN
  assign stalled = stall && (state_q == RUN);
`else
  assign stalled = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (!start) begin
      // Dropping start aborts or acknowledges completion; it overrides any stall.
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RUN;
          count_d = CW'(1);
        end
        RUN: begin
          if (!stalled) begin
            if (count_q == LastCount) begin
              state_d = DONE;
            end else begin
              count_d = count_q + CW'(1);
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign first_px = (count_q[2*LOG2N-1:0] == (2 * LOG2N)'(1)) && (state_q != IDLE);
  assign comp_on  = (count_q >= BlockSize);

  // Strobes are masked while stalled so a frozen count never repeats a pulse.
  assign NewDist   = {N{first_px && !stalled}};
  assign PEready   = {N{first_px && comp_on && !stalled}};
  assign CompStart = comp_on && !stalled;

  always_comb begin
    S1S2mux = '0;
    for (int i = 0; i < N; i++) begin
      S1S2mux[i] = (count_q[LOG2N-1:0] > LOG2N'(i));
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  me_addr_gen #(
    .N      (N),
    .V      (V),
    .OFFSET (OFFSET),
    .VEC_W  (VEC_W)
  ) u_addr_gen (
    .count     (count_q),
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .VectorX   (VectorX),
    .VectorY   (VectorY)
  );

endmodule

// File: tb/tb_me_control_param.sv
// Directed self-checking bench for me_control_param (default and N=4/V=4 builds).
module tb_me_control_param;

  localparam int TLAST = 4112;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic start_s;
  logic stall;

  logic [15:0] S1S2mux, NewDist, PEready;
  logic        CompStart, busy, done;
  logic [3:0]  VectorX, VectorY;
  logic [7:0]  AddressR;
  logic [9:0]  AddressS1;
  logic [8:0]  AddressS2;

  logic [3:0]  S1S2mux_s, NewDist_s, PEready_s;
  logic        CompStart_s, busy_s, done_s;
  logic [3:0]  VectorX_s, VectorY_s;
  logic [3:0]  AddressR_s;
  logic [5:0]  AddressS1_s;
  logic [4:0]  AddressS2_s;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  me_control_param dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
`ifdef ME_STALL_EN
    .stall     (stall),
`endif
    .S1S2mux   (S1S2mux),
    .NewDist   (NewDist),
    .CompStart (CompStart),
    .PEready   (PEready),
    .VectorX   (VectorX),
    .VectorY   (VectorY),
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .busy      (busy),
    .done      (done)
  );

  me_control_param #(
    .N      (4),
    .V      (4),
    .OFFSET (1),
    .VEC_W  (4)
  ) dut_s (
    .clock     (clock),
    .reset     (reset),
    .start     (start_s),
`ifdef ME_STALL_EN
    .stall     (1'b0),
`endif
    .S1S2mux   (S1S2mux_s),
    .NewDist   (NewDist_s),
    .CompStart (CompStart_s),
    .PEready   (PEready_s),
    .VectorX   (VectorX_s),
    .VectorY   (VectorY_s),
    .AddressR  (AddressR_s),
    .AddressS1 (AddressS1_s),
    .AddressS2 (AddressS2_s),
    .busy      (busy_s),
    .done      (done_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_mux"},   32'(S1S2mux),   32'h0);
    check({pfx, "_nd"},    32'(NewDist),   32'h0);
    check({pfx, "_per"},   32'(PEready),   32'h0);
    check({pfx, "_cs"},    32'(CompStart), 32'h0);
    check({pfx, "_busy"},  32'(busy),      32'h0);
    check({pfx, "_done"},  32'(done),      32'h0);
    check({pfx, "_ar"},    32'(AddressR),  32'h0);
    check({pfx, "_as1"},   32'(AddressS1), 32'h0);
    check({pfx, "_as2"},   32'(AddressS2), 32'h0);
    check({pfx, "_vx"},    32'(VectorX),   32'h9);
    check({pfx, "_vy"},    32'(VectorY),   32'h9);
  endtask

  // Full run from IDLE with start held; optional 5-cycle stall once the count reaches stall_at.
  task automatic run_search(input int stall_at, output int busy_n, output int pulses,
                            output int first_pe, output int last_pe, output int done_edge,
                            output int errs);
    int   cnt;
    int   st_left;
    bit   used;
    logic exp_pe;
    cnt = 0; st_left = 0; used = 0;
    busy_n = 0; pulses = 0; first_pe = -1; last_pe = -1; done_edge = 0; errs = 0;
    start = 1'b1;
    for (int e = 1; e <= 6000; e++) begin
      @(posedge clock);
      if (st_left > 0) st_left--;
      else if (cnt < TLAST) cnt++;
      #1;
      if (st_left == 0) stall = 1'b0;
      if (stall_at != 0 && !used && cnt == stall_at) begin
        stall = 1'b1;
        st_left = 5;
        used = 1;
      end
      #1;
      if (done) begin
        done_edge = e;
        break;
      end
      if (busy) busy_n++;
      exp_pe = (cnt % 256 == 1) && (cnt >= 256) && !stall;
      if (PEready !== (exp_pe ? 16'hFFFF : 16'h0)) errs++;
      if (AddressR !== 8'(cnt)) errs++;
      if (stall && NewDist !== 16'h0) errs++;
      if (PEready != 16'h0) begin
        pulses++;
        if (first_pe < 0) first_pe = cnt;
        last_pe = cnt;
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    int busy_n, pulses, first_pe, last_pe, done_edge, errs, done_seen, max_s1;
    reset = 1'b1; start = 1'b0; start_s = 1'b0; stall = 1'b0;
    tick();
    tick();
    reset_checks("rst");
    check("rst_small_vx", 32'(VectorX_s), 32'hF);
    reset = 1'b0;
    tick();

    // Full run with start held high.
    run_search(0, busy_n, pulses, first_pe, last_pe, done_edge, errs);
    check("run_busy_cycles", busy_n, 4112);
    check("run_done_edge", done_edge, 4113);
    check("run_pulses", pulses, 16);
    check("run_first_pe", first_pe, 257);
    check("run_last_pe", last_pe, 4097);
    check("run_model", errs, 0);
    check("done_ar", 32'(AddressR), 32'h10);
    check("done_vy", 32'(VectorY), 32'h9);
    check("done_cs", 32'(CompStart), 32'h1);
    for (int i = 0; i < 3; i++) tick();
    check("done_hold", 32'(done), 32'h1);
    check("done_hold_ar", 32'(AddressR), 32'h10);
    start = 1'b0;
    tick();
    check("ack_done", 32'(done), 32'h0);
    check("ack_busy", 32'(busy), 32'h0);
    check("ack_ar", 32'(AddressR), 32'h0);

    // Directed decodes on the way to an abort.
    start = 1'b1;
    done_seen = 0;
    for (int e = 1; e <= 1000; e++) begin
      tick();
      if (done) done_seen++;
      if (e == 1) begin
        check("c1_nd", 32'(NewDist), 32'hFFFF);
        check("c1_per", 32'(PEready), 32'h0);
        check("c1_cs", 32'(CompStart), 32'h0);
        check("c1_busy", 32'(busy), 32'h1);
      end
      if (e == 257) begin
        check("c257_per", 32'(PEready), 32'hFFFF);
        check("c257_cs", 32'(CompStart), 32'h1);
      end
      if (e == 291) begin
        check("c123_as1", 32'(AddressS1), 32'd99);
        check("c123_as2", 32'(AddressS2), 32'd51);
        check("c123_ar", 32'(AddressR), 32'h23);
        check("c123_mux", 32'(S1S2mux), 32'h0007);
        check("c123_vx", 32'(VectorX), 32'hC);
        check("c123_vy", 32'(VectorY), 32'hA);
        check("c123_nd", 32'(NewDist), 32'h0);
      end
    end
    check("abort_pre_ar", 32'(AddressR), 32'hE8);
    start = 1'b0;
    tick();
    check("abort_ar", 32'(AddressR), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    run_search(0, busy_n, pulses, first_pe, last_pe, done_edge, errs);
    check("rerun_busy_cycles", busy_n, 4112);
    check("rerun_done_edge", done_edge, 4113);
    check("rerun_pulses", pulses, 16);
    start = 1'b0;
    tick();

    // Asynchronous reset between clock edges.
    start = 1'b1;
    for (int e = 1; e <= 2000; e++) tick();
    check("pre_areset_busy", 32'(busy), 32'h1);
    check("pre_areset_ar", 32'(AddressR), 32'hD0);
    #3;
    reset = 1'b1;
    #1;
    reset_checks("areset");
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // N=4, V=4, OFFSET=1 instance.
    start_s = 1'b1;
    busy_n = 0; pulses = 0; first_pe = -1; last_pe = -1; done_edge = 0; errs = 0; max_s1 = 0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (done_s) begin
        done_edge = e;
        break;
      end
      if (busy_s) busy_n++;
      if (32'(AddressS1_s) > max_s1) max_s1 = 32'(AddressS1_s);
      if (PEready_s !== (((e % 16 == 1) && e >= 16) ? 4'hF : 4'h0)) errs++;
      if (PEready_s != 4'h0) begin
        pulses++;
        if (first_pe < 0) first_pe = e;
        last_pe = e;
      end
    end
    check("small_busy_cycles", busy_n, 68);
    check("small_done_edge", done_edge, 69);
    check("small_pulses", pulses, 4);
    check("small_first_pe", first_pe, 17);
    check("small_last_pe", last_pe, 65);
    check("small_max_s1", max_s1, 51);
    check("small_model", errs, 0);
    start_s = 1'b0;
    tick();

`ifdef ME_STALL_EN
    run_search(257, busy_n, pulses, first_pe, last_pe, done_edge, errs);
    check("stall_busy_cycles", busy_n, 4117);
    check("stall_done_edge", done_edge, 4118);
    check("stall_pulses", pulses, 16);
    check("stall_first_pe", first_pe, 257);
    check("stall_model", errs, 0);
    start = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
